// File: rtl/hsstlp_fifo_clr_rsp_pkg.sv
// Shared types and helpers for the HSST RX FIFO-clear responder.
package hsstlp_fifo_clr_rsp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } lane_state_e;

  localparam int BOND_NONE = 0;
  localparam int BOND_PAIR = 1;
  localparam int BOND_QUAD = 2;

  // Lanes that must all be ready before any member of lane's group may finish.
  function automatic logic [3:0] group_mask(input int lane, input int bond_mode);
    logic [3:0] mask;
    mask = 4'b0000;
    case (bond_mode)
      BOND_PAIR: mask = (lane < 2) ? 4'b0011 : 4'b1100;
      BOND_QUAD: mask = 4'b1111;
      default:   mask = 4'b0001 << lane[1:0];
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/hsstlp_fifo_clr_lane_fsm.sv
// Per-lane clear sequencer: hold the PCS FIFO clear, settle, then wait for the group.
module hsstlp_fifo_clr_lane_fsm
  import hsstlp_fifo_clr_rsp_pkg::*;
#(
  parameter int CLR_HOLD_CYC = 8,
  parameter int SETTLE_CYC   = 16,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic group_ready,
  input  logic enable,
  output logic pcs_fifo_clr,
  output logic busy,
  output logic done,
  output logic restart,
  output logic in_done
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(CLR_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  lane_state_e      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;

  assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign in_done   = (state_r == ST_DONE);
  assign restart   = req & enable & (state_r != ST_IDLE);

  // Lane state, counter and registered outputs; a new request always restarts the hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      pcs_fifo_clr <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!enable) begin
        state_r      <= ST_IDLE;
        cnt_r        <= {CNT_W{1'b0}};
        pcs_fifo_clr <= 1'b0;
        busy         <= 1'b0;
      end else if (req) begin
        state_r      <= ST_HOLD;
        cnt_r        <= {CNT_W{1'b0}};
        pcs_fifo_clr <= 1'b1;
        busy         <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            cnt_r <= {CNT_W{1'b0}};
          end
          ST_HOLD: begin
            if (cnt_r == HOLD_LAST) begin
              state_r      <= ST_SETTLE;
              cnt_r        <= {CNT_W{1'b0}};
              pcs_fifo_clr <= 1'b0;
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end
          ST_SETTLE: begin
            if (cnt_r == SETTLE_LAST) begin
              state_r <= ST_DONE;
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end
          ST_DONE: begin
            if (group_ready) begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r <= ST_DONE;
            end
          end
          default: begin
            state_r      <= ST_IDLE;
            pcs_fifo_clr <= 1'b0;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/hsstlp_fifo_clr_rsp.sv
// FIFO-clear responder top: request edge detection, bonding-group alignment, restart flags.
module hsstlp_fifo_clr_rsp
  import hsstlp_fifo_clr_rsp_pkg::*;
#(
  parameter logic [3:0] CH_RX_ENABLE = 4'b1111,
  parameter int         BOND_MODE    = 0,
  parameter int         CLR_HOLD_CYC = 8,
  parameter int         SETTLE_CYC   = 16,
  parameter int         CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] fifo_clr_en,
  input  logic       err_clr,
  output logic [3:0] pcs_fifo_clr,
  output logic [3:0] fifo_clr_busy,
  output logic [3:0] fifo_clr_done,
  output logic [3:0] clr_restart
);

  logic [3:0] en_ff1_r;
  logic       arm_r;
  logic [3:0] req_s;
  logic [3:0] in_done_s;
  logic [3:0] group_ready_s;
  logic [3:0] restart_s;

  // A level already high when reset releases is not a fresh request, so hold off one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_ff1_r <= 4'b0000;
      arm_r    <= 1'b0;
    end else begin
      en_ff1_r <= fifo_clr_en;
      arm_r    <= 1'b1;
    end
  end

  assign req_s = fifo_clr_en & ~en_ff1_r & CH_RX_ENABLE & {4{arm_r}};

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign group_ready_s[i] = &(in_done_s | ~CH_RX_ENABLE | ~group_mask(i, BOND_MODE));

    hsstlp_fifo_clr_lane_fsm #(
      .CLR_HOLD_CYC(CLR_HOLD_CYC),
      .SETTLE_CYC  (SETTLE_CYC),
      .CNT_W       (CNT_W)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req_s[i]),
      .group_ready (group_ready_s[i]),
      .enable      (CH_RX_ENABLE[i]),
      .pcs_fifo_clr(pcs_fifo_clr[i]),
      .busy        (fifo_clr_busy[i]),
      .done        (fifo_clr_done[i]),
      .restart     (restart_s[i]),
      .in_done     (in_done_s[i])
    );
  end

  // Sticky restart flags; a new restart beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_restart <= 4'b0000;
    end else begin
      clr_restart <= restart_s | (clr_restart & {4{~err_clr}});
    end
  end

endmodule
